// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: shared widths, opcodes and FSM state encoding for the simple CPU core
package simple_cpu_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h10;
  localparam logic [7:0] OP_LDM  = 8'h11;
  localparam logic [7:0] OP_ST   = 8'h20;
  localparam logic [7:0] OP_ADDI = 8'h30;
  localparam logic [7:0] OP_ADDM = 8'h31;
  localparam logic [7:0] OP_SUBI = 8'h40;
  localparam logic [7:0] OP_JZ   = 8'h60;
  localparam logic [7:0] OP_JMP  = 8'h70;
  localparam logic [7:0] OP_HALT = 8'hFF;
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
endpackage

// File: rtl/simple_cpu_alu.sv
// simple_cpu_alu: combinational add/subtract at DATA_W+1 bits, carry doubles as borrow on subtract
module simple_cpu_alu
  import simple_cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              carry
);
  logic [DATA_W:0] wide;
  always_comb begin
    wide = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    result = wide[DATA_W-1:0];
    carry = wide[DATA_W];
  end
endmodule

// File: rtl/simple_cpu_core.sv
// simple_cpu_core: FETCH/EXEC accumulator sequencer driving a 256x16 single-port RAM
module simple_cpu_core
  import simple_cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              zero,
  output logic              carry,
  output logic              halted,
  output logic              illegal
);
  logic [1:0]        state;
  logic [DATA_W-1:0] ir;
  logic [7:0]        op;
  logic [ADDR_W-1:0] opnd;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  always_comb begin
    op = ir[DATA_W-1 -: 8];
    opnd = ir[ADDR_W-1:0];
    imm = {{(DATA_W-8){1'b0}}, ir[7:0]};
    alu_b = (op == OP_ADDM) ? mem_rdata : imm;
    mem_addr = (state == ST_EXEC) ? opnd : pc;
    mem_we = (state == ST_EXEC) && (op == OP_ST) && !rst;
    mem_wdata = acc;
  end
  simple_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a(acc),
    .b(alu_b),
    .sub(op == OP_SUBI),
    .result(alu_res),
    .carry(alu_c)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      acc <= '0;
      ir <= '0;
      zero <= 1'b0;
      carry <= 1'b0;
      halted <= 1'b0;
      illegal <= 1'b0;
      state <= ST_FETCH;
    end else if (state == ST_FETCH) begin
      if (run) begin
        ir <= mem_rdata;
        pc <= pc + ADDR_W'(1);
        state <= ST_EXEC;
      end
    end else if (state == ST_EXEC) begin
      state <= ST_FETCH;
      case (op)
        OP_NOP, OP_ST: ;
        OP_LDI: begin
          acc <= imm;
          zero <= (imm == '0);
        end
        OP_LDM: begin
          acc <= mem_rdata;
          zero <= (mem_rdata == '0);
        end
        OP_ADDI, OP_ADDM, OP_SUBI: begin
          acc <= alu_res;
          carry <= alu_c;
          zero <= (alu_res == '0);
        end
        OP_JZ: if (zero) pc <= opnd;
        OP_JMP: pc <= opnd;
        OP_HALT: begin
          halted <= 1'b1;
          state <= ST_HALT;
        end
        default: begin
          halted <= 1'b1;
          illegal <= 1'b1;
          state <= ST_HALT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_simple_cpu_core.sv
// tb_simple_cpu_core: instruction-level reference model plus directed programs for simple_cpu_core
module tb_simple_cpu_core;
  logic        clk;
  logic        rst;
  logic        run;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [7:0]  pc;
  logic [15:0] acc;
  logic        zero;
  logic        carry;
  logic        halted;
  logic        illegal;
  logic [15:0] ram  [256];
  logic [15:0] mref [256];
  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  logic [7:0]  m_pc;
  logic [15:0] m_acc;
  logic [15:0] m_ir;
  logic        m_z;
  logic        m_c;
  logic        m_halt;
  logic        m_ill;
  logic        m_exec;
  simple_cpu_core dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .mem_rdata(mem_rdata),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .pc(pc),
    .acc(acc),
    .zero(zero),
    .carry(carry),
    .halted(halted),
    .illegal(illegal)
  );
  assign mem_rdata = ram[mem_addr];
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  initial begin
    m_pc = 0; m_acc = 0; m_ir = 0; m_z = 0; m_c = 0; m_halt = 0; m_ill = 0; m_exec = 0;
  end
  // Instruction-level model: one instruction = fetch edge followed by an execute edge.
  always @(posedge clk) begin : model
    int s;
    int opv;
    if (rst) begin
      m_pc <= 0; m_acc <= 0; m_ir <= 0; m_z <= 0; m_c <= 0; m_halt <= 0; m_ill <= 0; m_exec <= 0;
    end else if (!m_halt) begin
      if (!m_exec) begin
        if (run) begin
          m_ir <= mref[m_pc];
          m_pc <= m_pc + 8'd1;
          m_exec <= 1;
        end
      end else begin
        m_exec <= 0;
        opv = (m_ir[15:8] == 8'h11 || m_ir[15:8] == 8'h31) ? int'(mref[m_ir[7:0]]) : int'(m_ir[7:0]);
        case (m_ir[15:8])
          8'h00: ;
          8'h10, 8'h11: begin
            m_acc <= 16'(opv);
            m_z <= (opv == 0);
          end
          8'h20: mref[m_ir[7:0]] <= m_acc;
          8'h30, 8'h31: begin
            s = int'(m_acc) + opv;
            m_acc <= 16'(s % 65536);
            m_c <= (s > 65535);
            m_z <= (s % 65536 == 0);
          end
          8'h40: begin
            s = int'(m_acc) - opv;
            m_acc <= 16'((s + 65536) % 65536);
            m_c <= (s < 0);
            m_z <= (s == 0);
          end
          8'h60: if (m_z) m_pc <= m_ir[7:0];
          8'h70: m_pc <= m_ir[7:0];
          8'hFF: m_halt <= 1;
          default: begin
            m_halt <= 1;
            m_ill <= 1;
          end
        endcase
      end
    end
  end
  task automatic cmp(input string n, input logic [15:0] a, input logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("pc", 16'(pc), 16'(m_pc));
      cmp("acc", acc, m_acc);
      cmp("zero", 16'(zero), 16'(m_z));
      cmp("carry", 16'(carry), 16'(m_c));
      cmp("halted", 16'(halted), 16'(m_halt));
      cmp("illegal", 16'(illegal), 16'(m_ill));
      cmp("mem_we", 16'(mem_we), 16'(m_exec && m_ir[15:8] == 8'h20 && !rst));
      cmp("mem_addr", 16'(mem_addr), 16'(m_exec ? m_ir[7:0] : m_pc));
      cmp("mem_wdata", mem_wdata, m_acc);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic poke(input int a, input logic [15:0] v);
    ram[a] = v;
    mref[a] = v;
  endtask
  task automatic begin_prog();
    rst = 1;
    for (int i = 0; i < 256; i++) poke(i, 16'h0000);
  endtask
  task automatic check_reset(input string n);
    cmp({n, "_pc"}, 16'(pc), 16'h0000);
    cmp({n, "_acc"}, acc, 16'h0000);
    cmp({n, "_flags"}, 16'({zero, carry, halted, illegal}), 16'h0000);
    cmp({n, "_we"}, 16'(mem_we), 16'h0000);
  endtask
  task automatic go(input string n);
    tick();
    chk_en = 1;
    check_reset(n);
    rst = 0;
  endtask
  initial begin
    rst = 1;
    run = 1;
    begin_prog();
    poke(8'h00, 16'h1005);
    poke(8'h01, 16'h3003);
    poke(8'h02, 16'h20FF);
    poke(8'h03, 16'h7000);
    go("rst1");
    ticks(2);
    cmp("loop_e2_acc", acc, 16'h0005);
    ticks(2);
    cmp("loop_e4_acc", acc, 16'h0008);
    cmp("loop_e4_zero", 16'(zero), 16'h0000);
    tick();
    cmp("loop_st_we", 16'(mem_we), 16'h0001);
    cmp("loop_st_addr", 16'(mem_addr), 16'h00FF);
    cmp("loop_st_wdata", mem_wdata, 16'h0008);
    ticks(3);
    cmp("loop_e8_pc", 16'(pc), 16'h0000);
    ticks(8);
    cmp("loop_e16_pc", 16'(pc), 16'h0000);
    cmp("loop_e16_acc", acc, 16'h0008);
    cmp("loop_ram_ff", ram[8'hFF], 16'h0008);
    begin_prog();
    poke(8'h00, 16'h11F0);
    poke(8'h01, 16'h3001);
    poke(8'h02, 16'h6040);
    poke(8'hF0, 16'hFFFF);
    poke(8'h40, 16'h1007);
    poke(8'h41, 16'h6050);
    poke(8'h42, 16'h1000);
    poke(8'h43, 16'h4001);
    poke(8'h44, 16'hFF00);
    go("rst2");
    ticks(2);
    cmp("ldm_acc", acc, 16'hFFFF);
    ticks(2);
    cmp("addi_acc", acc, 16'h0000);
    cmp("addi_cz", 16'({carry, zero}), 16'h0003);
    ticks(2);
    cmp("jz_taken_pc", 16'(pc), 16'h0040);
    ticks(4);
    cmp("jz_fall_pc", 16'(pc), 16'h0042);
    ticks(4);
    cmp("subi_acc", acc, 16'hFFFF);
    cmp("subi_cz", 16'({carry, zero}), 16'h0002);
    ticks(2);
    cmp("halt_hi", 16'({halted, illegal}), 16'h0002);
    begin_prog();
    poke(8'h00, 16'h70FF);
    poke(8'hFF, 16'h70FF);
    go("rst3");
    ticks(2);
    cmp("wrap_jmp_pc", 16'(pc), 16'h00FF);
    tick();
    cmp("wrap_inc_pc", 16'(pc), 16'h0000);
    cmp("wrap_exec_addr", 16'(mem_addr), 16'h00FF);
    tick();
    cmp("wrap_self_pc", 16'(pc), 16'h00FF);
    ticks(4);
    cmp("wrap_loop_pc", 16'(pc), 16'h00FF);
    begin_prog();
    poke(8'h00, 16'h5500);
    go("rst4");
    ticks(2);
    cmp("ill_hi", 16'({halted, illegal}), 16'h0003);
    for (int i = 0; i < 20; i++) begin
      tick();
      cmp("ill_we", 16'(mem_we), 16'h0000);
      cmp("ill_pc", 16'(pc), 16'h0001);
      cmp("ill_acc", acc, 16'h0000);
    end
    rst = 1;
    tick();
    check_reset("ill_rst");
    rst = 0;
    tick();
    cmp("restart_pc", 16'(pc), 16'h0001);
    cmp("restart_halted", 16'(halted), 16'h0000);
    begin_prog();
    poke(8'h00, 16'h1009);
    poke(8'h01, 16'h2080);
    poke(8'h80, 16'h1234);
    run = 0;
    go("rst5");
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp("hold_pc", 16'(pc), 16'h0000);
      cmp("hold_addr", 16'(mem_addr), 16'h0000);
    end
    run = 1;
    tick();
    cmp("resume_pc", 16'(pc), 16'h0001);
    tick();
    cmp("resume_acc", acc, 16'h0009);
    tick();
    cmp("st_pending_we", 16'(mem_we), 16'h0001);
    rst = 1;
    #1;
    cmp("st_rst_we", 16'(mem_we), 16'h0000);
    tick();
    cmp("st_rst_ram", ram[8'h80], 16'h1234);
    cmp("st_rst_pc", 16'(pc), 16'h0000);
    rst = 0;
    tick();
    cmp("st_rst_fetch_pc", 16'(pc), 16'h0001);
    ticks(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/simple_cpu_core.md
Name: simple_cpu_core

Overview:
Instruction-sequencing master for the 256x16 single-port program/data RAM: fetches, decodes and executes 16-bit instructions against an accumulator, and drives the RAM's write-enable, address and write-data. The RAM has synchronous write and combinational read. This block sits between the top-level and the RAM as the only initiator on that interface. Each instruction takes a two-state FETCH/EXEC cycle.

Parameters:
ADDR_W, 8, memory address / PC width (256 words).
DATA_W, 16, memory word and accumulator width.
RESET_PC, 8'h00, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
run  input  1  1 = sequencer advances; 0 = hold in FETCH without fetching
mem_rdata  input  DATA_W  RAM combinational read data for mem_addr
mem_we  output  1  RAM write enable, combinational from state/IR
mem_addr  output  ADDR_W  RAM address: PC in FETCH, IR operand in EXEC
mem_wdata  output  DATA_W  RAM write data (= ACC)
pc  output  ADDR_W  program counter
acc  output  DATA_W  accumulator
zero  output  1  Z flag: ACC == 0 after last ACC-writing instruction
carry  output  1  C flag from last ADD/SUB
halted  output  1  core stopped (HALT or illegal opcode)
illegal  output  1  halt was caused by an undefined opcode

Behaviour:
- Reset (synchronous, rst=1 at edge): pc=RESET_PC, acc=0, ir=0, zero=0, carry=0, halted=0, illegal=0, state=FETCH. rst has priority over every other event, mid-instruction included. A pending EXEC store is abandoned: mem_we=0 while rst=1.
- Instruction format: ir[15:8] = opcode, ir[7:0] = operand. Immediates are zero-extended to DATA_W.
- States: FETCH, EXEC, HALT.
- FETCH: mem_addr=pc, mem_we=0. If run=1: ir<=mem_rdata, pc<=pc+1 (8-bit wrap, FF->00), go to EXEC. If run=0: hold, no register changes.
- EXEC: mem_addr=ir[7:0]. Next state is FETCH unless stated otherwise. run is ignored, so an instruction always completes.
- 0x00 NOP: no change.
- 0x10 LOAD_ACC_IMM: acc<=imm.
- 0x11 LOAD_ACC_MEM: acc<=mem_rdata.
- 0x20 STORE_ACC_MEM: mem_we=1 and mem_wdata=acc for this one cycle only; the RAM captures at the closing edge.
- 0x30 ADD_ACC_IMM / 0x31 ADD_ACC_MEM: {carry,acc}<=acc+operand, computed at DATA_W+1 bits.
- 0x40 SUB_ACC_IMM: {carry,acc}<=acc-imm. carry=1 means borrow.
- 0x60 JZ: if zero=1 then pc<=operand.
- 0x70 JUMP: pc<=operand.
- 0xFF HALT: halted<=1, go to HALT.
- Any other opcode: halted<=1, illegal<=1, go to HALT.
- zero updates on every acc write (loads, add, sub) using the new acc value. carry updates only on ADD/SUB.
- HALT: absorbing state. mem_we=0, mem_addr=pc. All registers hold until rst.
- mem_we is 0 in every state except EXEC with opcode 0x20. Glitch-free decode: derived from registered state and ir only.
- Throughput: one instruction per 2 clocks while run=1. Latency from fetch edge to visible ACC/PC result is 1 clock.
- Jump target written in EXEC overrides the pc+1 from FETCH. A jump to the current address (self-loop) is legal.
- Store to the word currently holding code is permitted. The new contents are fetched on the next pass (self-modifying code).

Decomposition:
- simple_cpu_pkg holds:
  - opcode localparams (OP_NOP, OP_LDI, OP_LDM, OP_ST, OP_ADDI, OP_ADDM, OP_SUBI, OP_JZ, OP_JMP, OP_HALT);
  - state encoding (ST_FETCH, ST_EXEC, ST_HALT);
  - ADDR_W/DATA_W defaults.
- One sub-module: simple_cpu_alu. It is combinational; inputs a, b, sub; outputs result[DATA_W-1:0], carry. The core holds the FSM and registers.

Test Plan:
- Program RAM {00:1005, 01:3003, 02:20FF, 03:7000}, release rst, run=1. Required response:
  - edge 2: acc=0005;
  - edge 4: acc=0008, zero=0;
  - during cycle 6: mem_we=1, mem_addr=FF, mem_wdata=0008;
  - edge 8: pc=00.
  Loop repeats identically.
- ACC=FFFF (via LDM), then ADDI 0x01 -> acc=0000, carry=1, zero=1. Next JZ 0x40 -> pc=40. With zero=0, JZ falls through to pc+1.
- SUBI 0x01 with acc=0000 -> acc=FFFF, carry=1 (borrow), zero=0.
- Word at FF = 70FF executed via pc wrap test: JUMP FF -> fetch from FF, pc increments to 00 then JUMP sets pc=FF. No X, no out-of-range address.
- Opcode 0x55 fetched -> halted=1, illegal=1, mem_we stays 0 for 20 cycles, pc/acc frozen. Then rst pulse -> all outputs at reset values and execution restarts at RESET_PC. Also check HALT (FF00): halted=1, illegal=0.
- run=0 held 5 cycles in FETCH: no pc/ir change. Assert rst during an EXEC STORE cycle: mem_we=0 that cycle, RAM target unchanged, state=FETCH next.
